alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Iterative multiply/divide unit beside the main ALU, downstream of the ALU source mux.
- Consumes SrcA (register file read data 1) and SrcB (the ALU source-mux output) and computes MIPS-style MULT/MULTU/DIV/DIVU into HI/LO registers over 33 cycles.
- Control stalls the PC while Busy is high; MFHI/MFLO read HI/LO directly, and MTHI/MTLO write them.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, 32, iteration cycles; must equal WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  launch operation; sampled only in IDLE.
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- SrcA  input  WIDTH  multiplicand / dividend.
- SrcB  input  WIDTH  multiplier / divisor (ALU source-mux output).
- HiWrite  input  1  MTHI strobe.
- LoWrite  input  1  MTLO strobe.
- WriteData  input  WIDTH  data for MTHI/MTLO.
- Busy  output  1  operation in progress; stall request.
- Done  output  1  one-cycle pulse when HI/LO have been updated by an operation.
- HI  output  WIDTH  high product / remainder.
- LO  output  WIDTH  low product / quotient.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; HI=0, LO=0, Busy=0, Done=0; iteration counter=0.
  - Reset mid-operation aborts the operation with no HI/LO update.
  - Reset overrides every other input on the same edge.
- State machine:
  - IDLE:
    - Start=1 at edge E0 latches Op and operands, converts signed operands to magnitudes (records result signs), counter=0, goes to RUN, Busy=1 after E0.
  - RUN:
    - One shift-add (multiply) or restoring shift-subtract (divide) step per edge, counter increments.
    - After ITER steps (edges E1..E32) goes to FIX.
  - FIX:
    - At edge E33, applies sign correction, writes HI/LO, Done=1, Busy=0, returns to IDLE.
    - Done is high for exactly the cycle after E33.
  - Total: result is visible 33 cycles after the Start edge. Back-to-back Start is allowed in the Done cycle.
- Start while Busy: ignored, no queueing.
- HiWrite/LoWrite:
  - Honoured only in IDLE when Start=0; HI or LO takes WriteData at that edge.
  - Both strobes high updates both registers.
  - Ignored while Busy or when Start=1 (Start wins).
- HI/LO hold their value while Busy; intermediate results are never exposed.
- Multiply: 64-bit product {HI,LO}. Signed result is negative iff operand signs differ, negated in two's complement at FIX.
- Divide:
  - LO=quotient, HI=remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0 (natural 32-bit wrap, no trap).
- Divide by zero (DIV or DIVU): HI=SrcA unchanged, LO=0xFFFFFFFF. Still takes 33 cycles with a normal Done.
- Operands are only sampled at E0; changes to SrcA/SrcB during RUN have no effect.

Decomposition:
- Shared package alu_muldiv_pkg:
  - Op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU.
  - State encoding IDLE/RUN/FIX.
  - Counter width clog2(ITER+1).
- One natural sub-module: muldiv_step, a combinational single-iteration datapath (shift-add or shift-subtract on a {rem/hi, acc/lo} 2*WIDTH register).
- The top level holds the FSM, counter, sign fix-up and HI/LO registers.

Test Plan:
- MULT SrcA=0xFFFFFFFD (-3), SrcB=5 -> Done exactly 33 cycles after the Start edge; HI=0xFFFFFFFF, LO=0xFFFFFFF1; Busy high for 33 cycles.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; then DIV -7/2 back-to-back (Start in Done cycle) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/0 -> HI=0x00000064, LO=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- During RUN: pulse Start with new operands, pulse HiWrite with 0x1234, change SrcA/SrcB -> all ignored; final result matches the original operands; HI is not 0x1234.
- In IDLE: HiWrite=1, LoWrite=1, WriteData=0xA5A5A5A5 -> both registers = 0xA5A5A5A5 the next cycle. Start=1 together with LoWrite=1 -> LO is not written by the strobe.
- Assert reset at RUN cycle 10 -> next cycle Busy=0, Done=0, HI=LO=0, state IDLE. A new Start afterwards completes normally in 33 cycles.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state codes and small decode helpers.
package alu_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    // Counter must be able to hold the value ITER itself.
    function automatic int cntWidth(input int iter);
        return $clog2(iter + 1);
    endfunction

    function automatic logic isSignedOp(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic isDivOp(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// One iteration of the unsigned datapath on the {hi, lo} working register.
// Multiply: lo holds the multiplier, operand is the multiplicand; add then
// shift right. Divide: lo holds the dividend/quotient, hi the partial
// remainder, operand is the divisor; restoring shift-subtract.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 isDiv,
    input  logic [2*WIDTH-1:0]   workIn,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   workOut
);

    logic [WIDTH-1:0] hiPart;
    logic [WIDTH-1:0] loPart;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH:0]   divDiff;

    assign hiPart = workIn[2*WIDTH-1:WIDTH];
    assign loPart = workIn[WIDTH-1:0];

    // Single shift-add or shift-subtract step; the borrow bit of the trial
    // subtraction decides whether the remainder is restored.
    always_comb begin
        mulSum   = {1'b0, hiPart} + (loPart[0] ? {1'b0, operand} : '0);
        divShift = {hiPart, loPart[WIDTH-1]};
        divDiff  = divShift - {1'b0, operand};
        workOut  = '0;
        if (isDiv) begin
            if (!divDiff[WIDTH]) begin
                workOut = {divDiff[WIDTH-1:0], loPart[WIDTH-2:0], 1'b1};
            end else begin
                workOut = {divShift[WIDTH-1:0], loPart[WIDTH-2:0], 1'b0};
            end
        end else begin
            workOut = {mulSum, loPart[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative MIPS-style MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Operands are captured as magnitudes at Start, ITER unsigned steps run,
// then a fix-up cycle applies signs and writes HI/LO.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CNT_W = cntWidth(ITER);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   count;
    logic               opIsDiv;
    logic               negResult;
    logic               negRemainder;
    logic               divZero;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] work;
    logic [2*WIDTH-1:0] stepOut;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic               doneReg;

    logic               startIsDiv;
    logic               signA;
    logic               signB;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;

    logic [2*WIDTH-1:0] prodFixed;
    logic [WIDTH-1:0]   quoFixed;
    logic [WIDTH-1:0]   remFixed;

    muldiv_step #(.WIDTH(WIDTH)) step (
        .isDiv   (opIsDiv),
        .workIn  (work),
        .operand (operand),
        .workOut (stepOut)
    );

    // Operand decode at launch: signed ops record signs and use magnitudes.
    always_comb begin
        startIsDiv = isDivOp(Op);
        signA      = isSignedOp(Op) & SrcA[WIDTH-1];
        signB      = isSignedOp(Op) & SrcB[WIDTH-1];
        magA       = signA ? -SrcA : SrcA;
        magB       = signB ? -SrcB : SrcB;
    end

    // Sign correction of the finished unsigned result; a zero divisor forces
    // an all-ones quotient, and the remainder path restores SrcA itself.
    always_comb begin
        prodFixed = negResult ? -work : work;
        remFixed  = negRemainder ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
        if (divZero) begin
            quoFixed = '1;
        end else begin
            quoFixed = negResult ? -work[WIDTH-1:0] : work[WIDTH-1:0];
        end
    end

    // Control FSM, iteration counter and the architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            opIsDiv      <= 1'b0;
            negResult    <= 1'b0;
            negRemainder <= 1'b0;
            divZero      <= 1'b0;
            operand      <= '0;
            work         <= '0;
            hiReg        <= '0;
            loReg        <= '0;
            doneReg      <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        opIsDiv      <= startIsDiv;
                        negResult    <= signA ^ signB;
                        negRemainder <= signA;
                        divZero      <= startIsDiv && (SrcB == '0);
                        operand      <= startIsDiv ? magB : magA;
                        work         <= {{WIDTH{1'b0}}, (startIsDiv ? magA : magB)};
                        count        <= '0;
                        state        <= RUN;
                    end else begin
                        if (HiWrite) begin
                            hiReg <= WriteData;
                        end
                        if (LoWrite) begin
                            loReg <= WriteData;
                        end
                    end
                end
                RUN: begin
                    work  <= stepOut;
                    count <= count + CNT_W'(1);
                    if (count == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (opIsDiv) begin
                        hiReg <= remFixed;
                        loReg <= quoFixed;
                    end else begin
                        hiReg <= prodFixed[2*WIDTH-1:WIDTH];
                        loReg <= prodFixed[WIDTH-1:0];
                    end
                    doneReg <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Busy = (state != IDLE);
    assign Done = doneReg;
    assign HI   = hiReg;
    assign LO   = loReg;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: table of known vectors plus random
// vectors against a behavioural model, and hand-written corner sequences.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         Start = 1'b0;
    logic [1:0]   Op = 2'b00;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic         HiWrite = 1'b0;
    logic         LoWrite = 1'b0;
    logic [W-1:0] WriteData = '0;
    logic         Busy;
    logic         Done;
    logic [W-1:0] HI;
    logic [W-1:0] LO;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        logic        backToBack;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t scoreboard[$];

    alu_muldiv #(.WIDTH(W), .ITER(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .Op        (Op),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .HiWrite   (HiWrite),
        .LoWrite   (LoWrite),
        .WriteData (WriteData),
        .Busy      (Busy),
        .Done      (Done),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clk = ~clk;

    // Behavioural reference using native wide arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      sres;
        logic [63:0] ures;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.hi = '0;
        e.lo = '0;
        case (op)
            OP_MULT: begin
                sres = sa * sb;
                ures = 64'(sres);
                e.hi = ures[63:32];
                e.lo = ures[31:0];
            end
            OP_MULTU: begin
                ures = {32'b0, a} * {32'b0, b};
                e.hi = ures[63:32];
                e.lo = ures[31:0];
            end
            OP_DIV: begin
                if (b == 0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                end else begin
                    sres = sa / sb;
                    ures = 64'(sres);
                    e.lo = ures[31:0];
                    sres = sa % sb;
                    ures = 64'(sres);
                    e.hi = ures[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkNotEqual(input string name, input logic [31:0] actual, input logic [31:0] forbidden);
        testsRun++;
        if (actual === forbidden) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, required anything but 0x%08h", name, actual, forbidden);
        end
    endtask

    // Called just after a clock edge; launches an op and records its expectation.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input exp_t expected);
        Op    = op;
        SrcA  = a;
        SrcB  = b;
        Start = 1'b1;
        scoreboard.push_back(expected);
        @(posedge clk);
        #1;
        Start = 1'b0;
        checkOutput("busy_after_start", {31'b0, Busy}, 32'd1);
    endtask

    // Waits (bounded) for Done, then pops the scoreboard and compares HI/LO and timing.
    task automatic waitResult(input string name, input int expEdges, input int expBusy);
        int   edges;
        int   busyCycles;
        logic seen;
        exp_t e;
        edges = 0;
        busyCycles = 1;
        seen = 1'b0;
        while (!seen && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (Done) begin
                seen = 1'b1;
            end else if (Busy) begin
                busyCycles++;
            end
        end
        if (!seen) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s_timeout: got no Done within %0d cycles, expected %0d", name, edges, expEdges);
            if (scoreboard.size() > 0) begin
                void'(scoreboard.pop_front());
            end
            return;
        end
        if (scoreboard.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s_scoreboard: got Done, expected no result pending", name);
            return;
        end
        e = scoreboard.pop_front();
        checkOutput({name, "_hi"}, HI, e.hi);
        checkOutput({name, "_lo"}, LO, e.lo);
        checkOutput({name, "_latency"}, 32'(edges), 32'(expEdges));
        checkOutput({name, "_busy"}, 32'(busyCycles), 32'(expBusy));
        checkOutput({name, "_busy_in_done"}, {31'b0, Busy}, 32'd0);
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        vec_t  vecs[$];
        exp_t  e;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs.push_back('{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, "mult_neg3x5"});
        vecs.push_back('{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, "multu_max"});
        vecs.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg7by2"});
        vecs.push_back('{OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b0, "divu_by0"});
        vecs.push_back('{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_overflow"});
        vecs.push_back('{OP_DIV,   32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b0, "div_neg_by0"});
        vecs.push_back('{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, "divu_by16"});
        vecs.push_back('{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div_7bym2"});
        vecs.push_back('{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mult_minsq"});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hi", HI, 32'h0);
        checkOutput("reset_lo", LO, 32'h0);
        checkOutput("reset_busy", {31'b0, Busy}, 32'd0);
        checkOutput("reset_done", {31'b0, Done}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven vectors; a backToBack entry chains the next start into its Done cycle
        for (int i = 0; i < vecs.size(); i++) begin
            e.hi = vecs[i].expHi;
            e.lo = vecs[i].expLo;
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, e);
            waitResult(vecs[i].name, 33, 33);
            if (!vecs[i].backToBack) begin
                @(posedge clk);
                #1;
                checkOutput({vecs[i].name, "_done_pulse"}, {31'b0, Done}, 32'd0);
            end
        end

        // Random vectors against the model
        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 2 == 0) ? 32'($urandom_range(0, 300)) - 32'd150 : $urandom;
            applyStimulus(rop, ra, rb, model(rop, ra, rb));
            waitResult("random", 33, 33);
        end
        @(posedge clk);
        #1;

        // Start, MTHI and operand changes during RUN are ignored
        applyStimulus(OP_MULT, 32'h0000_0007, 32'hFFFF_FFFE, model(OP_MULT, 32'h0000_0007, 32'hFFFF_FFFE));
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        Start     = 1'b1;
        Op        = OP_DIVU;
        SrcA      = 32'h0000_1111;
        SrcB      = 32'h0000_0003;
        HiWrite   = 1'b1;
        WriteData = 32'h0000_1234;
        @(posedge clk);
        #1;
        Start   = 1'b0;
        HiWrite = 1'b0;
        SrcA    = 32'hDEAD_BEEF;
        SrcB    = 32'h0BAD_F00D;
        checkNotEqual("run_hiwrite_ignored", HI, 32'h0000_1234);
        checkOutput("run_busy_held", {31'b0, Busy}, 32'd1);
        waitResult("run_ignore", 27, 27);
        checkNotEqual("run_final_hi_not_1234", HI, 32'h0000_1234);
        @(posedge clk);
        #1;

        // MTHI/MTLO in IDLE, then Start wins over LoWrite
        HiWrite   = 1'b1;
        LoWrite   = 1'b1;
        WriteData = 32'hA5A5_A5A5;
        @(posedge clk);
        #1;
        HiWrite = 1'b0;
        LoWrite = 1'b0;
        checkOutput("mthi", HI, 32'hA5A5_A5A5);
        checkOutput("mtlo", LO, 32'hA5A5_A5A5);
        LoWrite   = 1'b1;
        WriteData = 32'h0000_5555;
        e.hi = 32'h0;
        e.lo = 32'h6;
        applyStimulus(OP_MULTU, 32'h2, 32'h3, e);
        LoWrite = 1'b0;
        checkOutput("start_beats_lowrite", LO, 32'hA5A5_A5A5);
        waitResult("multu_2x3", 33, 33);
        @(posedge clk);
        #1;

        // Reset in RUN cycle 10 aborts, then a fresh op completes normally
        applyStimulus(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, model(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0));
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        scoreboard.delete();
        checkOutput("abort_busy", {31'b0, Busy}, 32'd0);
        checkOutput("abort_done", {31'b0, Done}, 32'd0);
        checkOutput("abort_hi", HI, 32'h0);
        checkOutput("abort_lo", LO, 32'h0);
        applyStimulus(OP_DIV, 32'hFFFF_FF9B, 32'h0000_0007, model(OP_DIV, 32'hFFFF_FF9B, 32'h0000_0007));
        waitResult("after_abort", 33, 33);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
